// File: rtl/output_accumulate_if.sv
// rtl/output_accumulate_if.sv - product stream in, quantized score vector out
interface output_accumulate_if #(
    parameter int PROD_W = 12
);
  logic                     start;
  logic                     prod_valid;
  logic signed [PROD_W-1:0] prod_data;
  logic                     prod_ready;
  logic                     busy;
  logic [0:9][3:0]          digit_weights;
  logic                     network_done;

  modport master (
    output start, prod_valid, prod_data,
    input  prod_ready, busy, digit_weights, network_done
  );

  modport slave (
    input  start, prod_valid, prod_data,
    output prod_ready, busy, digit_weights, network_done
  );
endinterface

// File: rtl/output_accumulate.sv
// rtl/output_accumulate.sv - ten saturating class accumulators, quantized to 4-bit scores
module output_accumulate #(
    parameter int N_IN   = 16,
    parameter int PROD_W = 12,
    parameter int ACC_W  = 20,
    parameter int SHIFT  = 6
) (
  input  logic clk,
  input  logic n_rst,
  output_accumulate_if.slave bus
);
  localparam int K_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX - SUM_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_QUANT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [10];
  logic signed [ACC_W-1:0] acc_d [10];
  logic [3:0]              n_q, n_d;
  logic [3:0]              q_q, q_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [0:9][3:0]         dw_q, dw_d;

  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] sat_val;
  logic signed [ACC_W-1:0] shr;
  logic [3:0]              q_idx;
  logic [3:0]              qval;

  // The sum is one bit wider than either operand so the clamp sees the true value.
  always_comb begin
    sum = SUM_W'(acc_q[n_q]) + SUM_W'(bus.prod_data);
    if (sum > ACC_MAX)      sat_val = ACC_MAX[ACC_W-1:0];
    else if (sum < ACC_MIN) sat_val = ACC_MIN[ACC_W-1:0];
    else                    sat_val = sum[ACC_W-1:0];
  end

  // q_q runs to 10 for the trailing cycle before DONE; keep the read index in range.
  always_comb begin
    q_idx = (q_q > 4'd9) ? 4'd9 : q_q;
    shr   = acc_q[q_idx] >>> SHIFT;
    if (acc_q[q_idx] < 0)                 qval = 4'd0;
    else if (shr > $signed(ACC_W'(15)))   qval = 4'd15;
    else                                  qval = shr[3:0];
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    q_d     = q_q;
    dw_d    = dw_q;
    for (int i = 0; i < 10; i++) acc_d[i] = acc_q[i];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACCUM;
          n_d     = 4'd0;
          k_d     = '0;
          q_d     = 4'd0;
          for (int i = 0; i < 10; i++) acc_d[i] = '0;
        end
      end
      S_ACCUM: begin
        if (bus.prod_valid) begin
          acc_d[n_q] = sat_val;
          if (n_q == 4'd9) begin
            n_d = 4'd0;
            if (k_q == K_W'(N_IN - 1)) begin
              state_d = S_QUANT;
              q_d     = 4'd0;
            end else begin
              k_d = k_q + K_W'(1);
            end
          end else begin
            n_d = n_q + 4'd1;
          end
        end
      end
      S_QUANT: begin
        if (q_q == 4'd10) begin
          state_d = S_DONE;
        end else begin
          dw_d[q_q] = qval;
          q_d       = q_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      n_q     <= 4'd0;
      k_q     <= '0;
      q_q     <= 4'd0;
      dw_q    <= '0;
      for (int i = 0; i < 10; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      q_q     <= q_d;
      dw_q    <= dw_d;
      for (int i = 0; i < 10; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign bus.prod_ready    = (state_q == S_ACCUM);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.network_done  = (state_q == S_DONE);
  assign bus.digit_weights = dw_q;
endmodule

// File: tb/tb_output_accumulate.sv
// tb/tb_output_accumulate.sv - directed vector bench for output_accumulate
module tb_output_accumulate;
  logic clk = 1'b0;
  logic n_rst = 1'b0;

  output_accumulate_if #(.PROD_W(12)) ifa ();
  output_accumulate_if #(.PROD_W(12)) ifb ();

  output_accumulate dut_a (.clk(clk), .n_rst(n_rst), .bus(ifa));
  output_accumulate #(.ACC_W(12)) dut_b (.clk(clk), .n_rst(n_rst), .bus(ifb));

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int              tid;
    bit              stalls;
    logic [0:9][3:0] exp_w;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic s, input logic v, input logic signed [11:0] d);
    ifa.start = s; ifa.prod_valid = v; ifa.prod_data = d;
    ifb.start = s; ifb.prod_valid = v; ifb.prod_data = d;
  endtask

  function automatic logic signed [11:0] gen(input int tid, input int k, input int n);
    case (tid)
      0: return (n == 5) ? 12'sd64 : 12'sd0;
      1: if (n == 2) return -12'sd50;
         else if (n == 3 && k == 0) return 12'sd100;
         else return 12'sd0;
      default: if (n == 0) return 12'sd2047;
               else if (n == 1) return -12'sd2048;
               else return 12'sd0;
    endcase
  endfunction

  task automatic feed(input int tid, input bit stalls, input int nbeats, output int not_ready);
    not_ready = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (stalls && $urandom_range(0, 2) == 0) begin
        drive(1'($urandom_range(0, 1)), 1'b0, 12'sd0);
        @(posedge clk); #1;
      end
      drive(1'b0, 1'b1, gen(tid, b / 10, b % 10));
      if (!ifa.prod_ready || !ifb.prod_ready) not_ready++;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 12'sd0);
    end
  endtask

  task automatic run(input int tid, input bit stalls);
    int nr;
    int lat;
    drive(1'b1, 1'b0, 12'sd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 12'sd0);
    feed(tid, stalls, 160, nr);
    check("ready_all_beats", 64'(nr), 64'd0);
    lat = 0;
    while (!ifa.network_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_latency", 64'(lat), 64'd11);
    check("done_b", 64'(ifb.network_done), 64'd1);
    check("busy_at_done", 64'(ifa.busy), 64'd1);
    drive(1'b1, 1'b0, 12'sd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 12'sd0);
    check("done_single_pulse", 64'(ifa.network_done), 64'd0);
    check("busy_drop", 64'(ifa.busy), 64'd0);
    @(posedge clk); #1;
    check("start_in_done_ignored", 64'(ifa.busy), 64'd0);
  endtask

  initial begin
    int nr;
    vecs[0] = '{tid: 0, stalls: 1'b0, exp_w: 40'h00000F0000};
    vecs[1] = '{tid: 1, stalls: 1'b0, exp_w: 40'h0001000000};
    vecs[2] = '{tid: 0, stalls: 1'b1, exp_w: 40'h00000F0000};
    vecs[3] = '{tid: 2, stalls: 1'b0, exp_w: 40'hF000000000};

    drive(1'b0, 1'b0, 12'sd0);
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_weights", 64'(ifa.digit_weights), 64'd0);
    check("rst_done", 64'(ifa.network_done), 64'd0);
    check("rst_ready", 64'(ifa.prod_ready), 64'd0);
    check("rst_busy", 64'(ifa.busy), 64'd0);
    n_rst = 1'b1;
    drive(1'b0, 1'b1, 12'sd64);
    @(posedge clk); #1;
    check("idle_ignores_valid", 64'(ifa.busy), 64'd0);
    drive(1'b0, 1'b0, 12'sd0);

    for (int i = 0; i < 4; i++) begin
      run(vecs[i].tid, vecs[i].stalls);
      check($sformatf("weights_a_%0d", i), 64'(ifa.digit_weights), 64'(vecs[i].exp_w));
      check($sformatf("weights_b_%0d", i), 64'(ifb.digit_weights), 64'(vecs[i].exp_w));
    end
    check("sat_acc0_pos", 64'($signed(dut_b.acc_q[0])), 64'(2047));
    check("sat_acc1_neg", 64'($signed(dut_b.acc_q[1])), 64'(-2048));
    check("nosat_acc0_wide", 64'($signed(dut_a.acc_q[0])), 64'(32752));

    drive(1'b1, 1'b0, 12'sd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 12'sd0);
    feed(0, 1'b0, 37, nr);
    check("partial_no_done", 64'(ifa.network_done), 64'd0);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_ready", 64'(ifa.prod_ready), 64'd0);
    check("midrst_busy", 64'(ifa.busy), 64'd0);
    check("midrst_done", 64'(ifa.network_done), 64'd0);
    check("midrst_weights", 64'(ifa.digit_weights), 64'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    run(0, 1'b0);
    check("after_rst_weights_a", 64'(ifa.digit_weights), 64'h00000F0000);
    check("after_rst_weights_b", 64'(ifb.digit_weights), 64'h00000F0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/output_accumulate.md
Name: output_accumulate

Overview:
- Final network layer stage, directly upstream of digit_decode.
- Consumes a serial stream of signed hidden-to-output products and accumulates one sum per digit class (10 classes).
- Quantizes each sum to a 4-bit unsigned score and presents the ten scores as a packed vector.
- Pulses network_done when the vector is valid, which starts the digit_decode arg-max scan.

Parameters:
N_IN, 16, number of hidden activations feeding each output neuron
PROD_W, 12, width of signed product input
ACC_W, 20, width of each signed accumulator (must be >= PROD_W + clog2(N_IN))
SHIFT, 6, arithmetic right shift applied during quantization

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  begin new inference; sampled only in IDLE
prod_valid  in  1  prod_data valid this cycle
prod_data  in  PROD_W  signed product, two's complement
prod_ready  out  1  high while in ACCUM; a beat is accepted when prod_valid && prod_ready
busy  out  1  high in ACCUM, QUANT and DONE
digit_weights  out  [0:9][3:0]  quantized scores, index = digit
network_done  out  1  one-cycle pulse, digit_weights valid

Behaviour:
- Reset (async, n_rst low): state IDLE, all accumulators 0, counters 0, digit_weights all 0, network_done 0, prod_ready 0, busy 0.
- Reset mid-operation aborts the inference immediately; no network_done is produced.
- FSM states: IDLE, ACCUM, QUANT, DONE. All outputs are registered or decoded from the state register only; there are no combinational paths from inputs.
- IDLE:
  - On start=1: clear all 10 accumulators, neuron counter and input counter; go to ACCUM next cycle.
  - prod_valid is ignored.
- ACCUM:
  - Stream order: input k = 0..N_IN-1 outer, neuron n = 0..9 inner, i.e. 10*N_IN beats total.
  - On each accepted beat: acc[n] <= sat(acc[n] + sext(prod_data)); then increment n, wrapping 9 -> 0 and incrementing k on wrap.
  - Cycles with prod_valid=0 are stalls; counters hold.
  - sat clamps the result to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]; no wrap-around is permitted.
  - Accepting the beat with k=N_IN-1, n=9 moves to QUANT next cycle.
  - start is ignored.
- QUANT:
  - Exactly 10 cycles, one neuron q = 0..9 per cycle.
  - digit_weights[q] <= 0 if acc[q] < 0.
  - Otherwise digit_weights[q] <= min(acc[q] >>> SHIFT, 15).
  - Entries not yet rewritten keep their previous values.
  - prod_ready=0. start is ignored.
- DONE:
  - network_done=1 for exactly one cycle, then IDLE.
  - start asserted during DONE is ignored; it must be re-asserted in IDLE.
- Latency: if the final beat is accepted on edge T, the QUANT writes occur on edges T+1..T+10, network_done is high in the cycle after edge T+11, and busy drops on edge T+12.
- digit_weights holds stable from network_done until the next QUANT. This satisfies digit_decode's requirement for a stable vector during its 10-cycle scan.
- Tie handling and arg-max are not done here; both belong to digit_decode.

Test Plan:
- Reset: hold n_rst low 2 cycles -> digit_weights all 0, network_done 0, prod_ready 0, busy 0.
- Single hot class (defaults): start; 160 beats, +64 for n=5 and 0 otherwise -> acc5=1024, digit_weights[5]=15 (clamped from 16), all others 0; network_done is a single pulse 11 cycles after the last accepted beat.
- Negative and partial values: n=2 gets -50 each beat, n=3 gets +100 only at k=0, rest 0 -> digit_weights[2]=0, digit_weights[3]=1, others 0.
- Stalls and ignored start: insert random prod_valid=0 gaps and pulse start during ACCUM -> same result as the gap-free run; beat count unaffected; prod_ready stays 1 until the 160th beat.
- Saturation: ACC_W=12, n=0 gets +2047 every beat -> acc0 pins at 2047, digit_weights[0]=15; n=1 gets -2048 every beat -> acc1 pins at -2048, digit_weights[1]=0.
- Reset mid-ACCUM after 37 beats -> immediate IDLE, all outputs 0; a new start then requires a full 160 beats before network_done.
